// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the sequential shift-add multiplier.
//   - state_e   : FSM states; each encoding equals the 7-segment stage code.
//   - STAGE_ERR : stage code shown ("E") when the state register is illegal.
//   - N_DEFAULT : default operand width.
//   - stage_of(): maps a state to its stage code, illegal encodings to STAGE_ERR.
package mult_pkg;

  localparam int unsigned N_DEFAULT = 8;
  localparam logic [2:0]  STAGE_ERR = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MULT  = 3'd2,
    ST_ZERO  = 3'd3,
    ST_DONE  = 3'd4,
    ST_CLEAR = 3'd5
  } state_e;

  function automatic logic [2:0] stage_of(input state_e s);
    case (s)
      ST_IDLE, ST_LOAD, ST_MULT, ST_ZERO, ST_DONE, ST_CLEAR: return 3'(s);
      default:                                                return STAGE_ERR;
    endcase
  endfunction

endpackage

// File: rtl/mult8x8_seq_if.sv
// mult8x8_seq_if: start/done/ack handshake bundle of the sequential multiplier.
//   start   : request a multiply (master -> slave)
//   a, b    : N-bit unsigned operands (master -> slave)
//   ack     : result acknowledge (master -> slave)
//   product : 2N-bit registered result (slave -> master)
//   busy    : high in every state but IDLE (slave -> master)
//   done    : result valid (slave -> master)
//   stage   : 3-bit phase code for the 7-segment decoder (slave -> master)
interface mult8x8_seq_if #(
  parameter int unsigned N = 8
);

  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           ack;
  logic [2*N-1:0] product;
  logic           busy;
  logic           done;
  logic [2:0]     stage;

  modport master (
    output start, a, b, ack,
    input  product, busy, done, stage
  );

  modport slave (
    input  start, a, b, ack,
    output product, busy, done, stage
  );

endinterface

// File: rtl/shift_add_dp.sv
// shift_add_dp: operand/accumulator datapath of the shift-add multiplier.
//   clk, rst_n     : clock, asynchronous active-low reset
//   i_load         : capture i_a (zero-extended) / i_b, clear accumulator
//   i_step         : one shift-add iteration
//   i_clr          : clear every register
//   i_a, i_b       : operands
//   o_mcand_zero   : multiplicand register is zero
//   o_mplr_zero    : multiplier register is zero
//   o_acc          : accumulator including this cycle's partial product, so
//                    the last MULT cycle can hand the finished sum straight on
module shift_add_dp
  import mult_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic           i_step,
  input  logic           i_clr,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_mcand_zero,
  output logic           o_mplr_zero,
  output logic [2*N-1:0] o_acc
);

  logic [2*N-1:0] r_mcand;
  logic [N-1:0]   r_mplr;
  logic [2*N-1:0] r_acc;
  logic [2*N-1:0] w_acc_sum;

  // 2N bits hold 255*255, so the sum never carries out.
  assign w_acc_sum    = r_mplr[0] ? (r_acc + r_mcand) : r_acc;
  assign o_acc        = w_acc_sum;
  assign o_mcand_zero = (r_mcand == '0);
  assign o_mplr_zero  = (r_mplr == '0);

  // NOTE: registers are written with <= so every flop samples pre-edge values;
  // blocking = here would let r_mcand shift before the add reads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
    end else if (i_clr) begin
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
    end else if (i_load) begin
      r_mcand <= {{N{1'b0}}, i_a};
      r_mplr  <= i_b;
      r_acc   <= '0;
    end else if (i_step) begin
      r_acc   <= w_acc_sum;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
    end
  end

endmodule

// File: rtl/mult8x8_seq.sv
// mult8x8_seq: sequential N x N unsigned shift-add multiplier with a
// start/done/ack handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mult8x8_seq_if slave (start, a, b, ack in; product, busy,
//                done, stage out)
// busy/done/stage are flops decoded from the state register, so they trail the
// state by one cycle: done rises N+2 cycles after the edge that accepts start
// (3 cycles for a zero operand), while ack/start are still judged on the state.
module mult8x8_seq
  import mult_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  mult8x8_seq_if.slave bus
);

  localparam int unsigned   CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_e         r_state;
  state_e         w_next_state;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_next;
  logic [2*N-1:0] r_product;
  logic [2*N-1:0] w_product_next;
  logic           r_busy;
  logic           r_done;
  logic [2:0]     r_stage;

  logic           w_load;
  logic           w_step;
  logic           w_clr;
  logic           w_mcand_zero;
  logic           w_mplr_zero;
  logic [2*N-1:0] w_acc;

  shift_add_dp #(.N(N)) u_dp (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_load),
    .i_step       (w_step),
    .i_clr        (w_clr),
    .i_a          (bus.a),
    .i_b          (bus.b),
    .o_mcand_zero (w_mcand_zero),
    .o_mplr_zero  (w_mplr_zero),
    .o_acc        (w_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_cnt_next     = r_cnt;
    w_product_next = r_product;
    w_load         = 1'b0;
    w_step         = 1'b0;
    w_clr          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_cnt_next   = '0;
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_next_state = (w_mcand_zero || w_mplr_zero) ? ST_ZERO : ST_MULT;
      end
      ST_MULT: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) begin
          // w_acc already includes this cycle's add.
          w_product_next = w_acc;
          w_cnt_next     = '0;
          w_next_state   = ST_DONE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_ZERO: begin
        w_product_next = '0;
        w_next_state   = ST_DONE;
      end
      ST_DONE: begin
        // A coincident start is dropped; only ack matters here.
        if (bus.ack) w_next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        w_product_next = '0;
        w_clr          = 1'b1;
        w_next_state   = ST_IDLE;
      end
      default: begin
        w_clr        = 1'b1;
        w_cnt_next   = '0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_stage   <= 3'd0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_product <= w_product_next;
      r_busy    <= (r_state != ST_IDLE);
      r_done    <= (r_state == ST_DONE);
      r_stage   <= stage_of(r_state);
    end
  end

  assign bus.product = r_product;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.stage   = r_stage;

endmodule

// File: tb/tb_mult8x8_seq.sv
// tb_mult8x8_seq: directed self-checking bench for mult8x8_seq. Expected
// products go into a scoreboard queue when start is driven and are popped when
// done rises; stage sequences and latencies are checked cycle by cycle.
module tb_mult8x8_seq;

  localparam int N = 8;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  mult8x8_seq_if #(.N(N)) bus ();

  mult8x8_seq #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives start for exactly one sampling edge (edge 0) and records the result.
  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    sb.push_back(32'(av) * 32'(bv));
    tick();
    bus.start = 1'b0;
  endtask

  // Call right after edge 0; waits a bounded number of cycles for done.
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    logic [31:0] exp;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_product"}, 32'(bus.product), exp);
  endtask

  // Acks the result; returns with the block in IDLE, ready to sample start.
  task automatic ack_to_idle(input string tag);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    tick();
    check({tag, "_clear_stage"}, 32'(bus.stage), 32'd5);
    check({tag, "_clear_product"}, 32'(bus.product), 32'd0);
    check({tag, "_clear_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [2:0] exp_stage;
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_product", 32'(bus.product), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_stage", 32'(bus.stage), 32'd0);
    rst_n = 1'b1;
    tick();

    // 13 x 11 with full stage trace: 1, 2 x8, 4
    issue(8'd13, 8'd11);
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_stage = (i == 1) ? 3'd1 : (i == 10) ? 3'd4 : 3'd2;
      check($sformatf("t1_stage_c%0d", i), 32'(bus.stage), 32'(exp_stage));
      check($sformatf("t1_done_c%0d", i), 32'(bus.done), (i == 10) ? 32'd1 : 32'd0);
    end
    check("t1_product", 32'(bus.product), sb.pop_front());
    for (int i = 0; i < 3; i++) tick();
    check("t1_done_held", 32'(bus.done), 32'd1);
    check("t1_product_held", 32'(bus.product), 32'd143);
    ack_to_idle("t1");
    tick();
    check("t1_idle_stage", 32'(bus.stage), 32'd0);
    check("t1_idle_busy", 32'(bus.busy), 32'd0);

    // Extremes
    issue(8'd255, 8'd255);
    wait_done("max", 10);
    ack_to_idle("max");
    issue(8'd1, 8'd128);
    wait_done("one_x128", 10);
    ack_to_idle("one_x128");

    // Zero operand: 1, 3, 4
    issue(8'd0, 8'd77);
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_stage = (i == 1) ? 3'd1 : (i == 2) ? 3'd3 : 3'd4;
      check($sformatf("zero_stage_c%0d", i), 32'(bus.stage), 32'(exp_stage));
      check($sformatf("zero_done_c%0d", i), 32'(bus.done), (i == 3) ? 32'd1 : 32'd0);
    end
    check("zero_product", 32'(bus.product), sb.pop_front());
    ack_to_idle("zero");
    issue(8'd200, 8'd0);
    wait_done("zero_b", 3);
    ack_to_idle("zero_b");

    // start held through MULT while a/b wander: only captured operands count
    bus.a     = 8'd6;
    bus.b     = 8'd7;
    bus.start = 1'b1;
    sb.push_back(32'd42);
    tick();
    for (int i = 1; i <= 9; i++) begin
      bus.a = 8'(i * 37);
      bus.b = 8'(i * 91 + 3);
      tick();
      check($sformatf("hold_nodone_c%0d", i), 32'(bus.done), 32'd0);
    end
    bus.start = 1'b0;
    tick();
    check("hold_done", 32'(bus.done), 32'd1);
    check("hold_product", 32'(bus.product), sb.pop_front());
    ack_to_idle("hold");

    // ack pulsed mid-MULT is ignored
    issue(8'd9, 8'd10);
    tick();
    tick();
    tick();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    for (int i = 5; i <= 9; i++) begin
      tick();
      check($sformatf("ackmid_busy_c%0d", i), 32'(bus.busy), 32'd1);
    end
    tick();
    check("ackmid_done_c10", 32'(bus.done), 32'd1);
    check("ackmid_product", 32'(bus.product), sb.pop_front());
    ack_to_idle("ackmid");

    // Asynchronous reset at MULT cycle 5
    issue(8'd200, 8'd100);
    for (int i = 1; i <= 6; i++) tick();
    check("arst_pre_stage", 32'(bus.stage), 32'd2);
    void'(sb.pop_back());
    #1 rst_n = 1'b0;
    #1;
    check("arst_product", 32'(bus.product), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_stage", 32'(bus.stage), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(8'd3, 8'd5);
    wait_done("post_rst", 10);

    // start + ack together in DONE: ack wins, no new multiply
    bus.a     = 8'd4;
    bus.b     = 8'd4;
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    tick();
    check("both_stage_clear", 32'(bus.stage), 32'd5);
    check("both_product_clear", 32'(bus.product), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("both_idle_busy_%0d", i), 32'(bus.busy), 32'd0);
      check($sformatf("both_idle_stage_%0d", i), 32'(bus.stage), 32'd0);
      check($sformatf("both_idle_product_%0d", i), 32'(bus.product), 32'd0);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
